// File: rtl/regfile_port_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_driver_pkg
// Description : Shared widths, command codes and FSM encoding for the
//               register-file port driver.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_port_driver_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    localparam logic CMD_DUMP  = 1'b0;
    localparam logic CMD_CLEAR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_port_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_driver_if
// Description : Register-file write/read port plus the valid/ready output
//               stream, as seen from the driver (master) and target (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_port_driver_if;
    import regfile_port_driver_pkg::*;

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output ra, we, wa, wd, out_data, out_idx, out_valid,
        input  rd, out_ready
    );

    modport slave (
        input  ra, we, wa, wd, out_data, out_idx, out_valid,
        output rd, out_ready
    );

endinterface
`default_nettype wire

// File: rtl/regfile_port_driver.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_driver
// Description : Clears R1..R7 or dumps R0..R7 over a valid/ready stream with
//               a running checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_port_driver
    import regfile_port_driver_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic              mode,
    input  wire logic              abort,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      checksum,
    regfile_port_driver_if.master  rf
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_idx;
    logic [DATA_W-1:0]  r_out_data;
    logic [ADDR_W-1:0]  r_out_idx;
    logic [DATA_W-1:0]  r_checksum;

    logic               w_idx_clr;
    logic               w_idx_one;
    logic               w_idx_inc;
    logic               w_capture;
    logic               w_accum;
    logic               w_cks_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // abort overrides every transition, including the final one into DONE
    always_comb begin
        w_state_nxt = r_state;
        w_idx_clr   = 1'b0;
        w_idx_one   = 1'b0;
        w_idx_inc   = 1'b0;
        w_capture   = 1'b0;
        w_accum     = 1'b0;
        w_cks_clr   = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode == CMD_CLEAR) begin
                            w_state_nxt = ST_CLEAR;
                            w_idx_one   = 1'b1;
                        end else begin
                            w_state_nxt = ST_LOAD;
                            w_idx_clr   = 1'b1;
                            w_cks_clr   = 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
                ST_LOAD: begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_SEND;
                end
                ST_SEND: begin
                    if (rf.out_ready) begin
                        w_accum = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_idx_inc   = 1'b1;
                            w_state_nxt = ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_out_data <= '0;
            r_out_idx  <= '0;
            r_checksum <= '0;
        end else begin
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_one) begin
                r_idx <= ADDR_W'(1);
            end else if (w_idx_inc) begin
                r_idx <= r_idx + ADDR_W'(1);
            end
            if (w_capture) begin
                r_out_data <= rf.rd;
                r_out_idx  <= r_idx;
            end
            if (w_cks_clr) begin
                r_checksum <= '0;
            end else if (w_accum) begin
                r_checksum <= r_checksum + r_out_data;
            end
        end
    end

    assign rf.ra        = r_idx;
    assign rf.we        = (r_state == ST_CLEAR);
    assign rf.wa        = (r_state == ST_CLEAR) ? r_idx : '0;
    assign rf.wd        = '0;
    assign rf.out_data  = r_out_data;
    assign rf.out_idx   = r_out_idx;
    assign rf.out_valid = (r_state == ST_SEND);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign checksum     = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_port_driver
// Description : Drives the port driver against a behavioural register file
//               and checks streams, clears, aborts and resets against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_port_driver;
    import regfile_port_driver_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mode;
    logic              abort;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    logic              pl_we;
    logic [ADDR_W-1:0] pl_wa;
    logic [DATA_W-1:0] pl_wd;
    logic [DATA_W-1:0] mem   [NUM_REGS];
    logic [DATA_W-1:0] model [NUM_REGS];

    int total = 0;
    int bad   = 0;

    regfile_port_driver_if rf ();

    regfile_port_driver dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .rf       (rf.master)
    );

    always #5 clk = ~clk;

    // Register file target: combinational read, write on rising edge
    assign rf.rd = mem[rf.ra];
    always @(posedge clk) begin
        if (rf.we) mem[rf.wa] <= rf.wd;
        else if (pl_we) mem[pl_wa] <= pl_wd;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < NUM_REGS; i++) begin
            pl_we = 1'b1;
            pl_wa = ADDR_W'(i);
            pl_wd = model[i];
            step();
        end
        pl_we = 1'b0;
    endtask

    task automatic random_model();
        for (int i = 0; i < NUM_REGS; i++) model[i] = DATA_W'($urandom_range(0, 255));
    endtask

    // bp: 0 = ready always high, 1 = ready high roughly one cycle in three
    task automatic run_dump(input int bp, input int abort_idx, input bit chk_lat);
        int n = 0, cnt = 0, done_cyc = 0;
        bit done_seen = 0, aborted = 0, stalled = 0, rdy;
        logic [DATA_W-1:0] sum = '0;
        logic [DATA_W-1:0] held_d = '0;
        logic [ADDR_W-1:0] held_i = '0;
        start = 1'b1; mode = CMD_DUMP;
        step();
        n = 1;
        while (n < 400) begin
            if (done) begin
                done_seen = 1; done_cyc = n;
                start = 1'b0;
                break;
            end
            if (stalled) begin
                total++;
                if (rf.out_valid !== 1'b1 || rf.out_data !== held_d || rf.out_idx !== held_i) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%b data=%h idx=%0d required valid=1 data=%h idx=%0d",
                             rf.out_valid, rf.out_data, rf.out_idx, held_d, held_i);
                end
            end
            rdy = (bp == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            rf.out_ready = rdy;
            start = 1'($urandom_range(0, 1));
            mode  = 1'($urandom_range(0, 1));
            if (abort_idx >= 0 && rf.out_valid && int'(rf.out_idx) == abort_idx) begin
                abort = 1'b1; start = 1'b0; aborted = 1;
                step();
                break;
            end
            if (rf.out_valid && rdy) begin
                total++;
                if (int'(rf.out_idx) !== cnt || rf.out_data !== model[cnt & 7]) begin
                    bad++;
                    $display("FAIL stream_item: idx=%0d data=%h required idx=%0d data=%h",
                             rf.out_idx, rf.out_data, cnt, model[cnt & 7]);
                end
                sum = sum + model[cnt & 7];
                cnt++;
            end
            stalled = rf.out_valid && !rdy;
            held_d = rf.out_data; held_i = rf.out_idx;
            step();
            n++;
        end
        start = 1'b0; rf.out_ready = 1'b0;
        if (aborted) begin
            total++;
            if (busy !== 1'b0 || rf.out_valid !== 1'b0 || rf.we !== 1'b0 || done !== 1'b0 || checksum !== sum) begin
                bad++;
                $display("FAIL abort_exit: busy=%b valid=%b we=%b done=%b cks=%h required 0 0 0 0 cks=%h",
                         busy, rf.out_valid, rf.we, done, checksum, sum);
            end
            abort = 1'b0;
            step();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_done: done=%b busy=%b required 0 0", done, busy);
            end
        end else if (!done_seen) begin
            total++; bad++;
            $display("FAIL dump_timeout: no done after %0d cycles required done", n);
        end else begin
            total++;
            if (cnt !== NUM_REGS || checksum !== sum) begin
                bad++;
                $display("FAIL dump_result: items=%0d cks=%h required items=%0d cks=%h",
                         cnt, checksum, NUM_REGS, sum);
            end
            total++;
            if (rf.ra !== LAST_IDX) begin
                bad++;
                $display("FAIL idx_nowrap: ra=%0d required %0d", rf.ra, LAST_IDX);
            end
            if (chk_lat) begin
                total++;
                if (done_cyc !== 17) begin
                    bad++;
                    $display("FAIL dump_latency: done at cycle %0d required 17", done_cyc);
                end
            end
            step();
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || checksum !== sum) begin
                bad++;
                $display("FAIL dump_after: done=%b busy=%b cks=%h required 0 0 %h", done, busy, checksum, sum);
            end
        end
    endtask

    task automatic run_clear();
        int n = 0, wecnt = 0, done_cyc = 0;
        logic [ADDR_W-1:0] exp_wa = ADDR_W'(1);
        start = 1'b1; mode = CMD_CLEAR;
        step();
        n = 1;
        while (n < 50 && !done) begin
            total++;
            if (rf.we !== 1'b1 || rf.wa !== exp_wa || rf.wd !== '0) begin
                bad++;
                $display("FAIL clear_write: we=%b wa=%0d wd=%h required 1 %0d 00", rf.we, rf.wa, rf.wd, exp_wa);
            end
            exp_wa = exp_wa + ADDR_W'(1);
            wecnt++;
            start = 1'($urandom_range(0, 1));
            mode  = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        done_cyc = n;
        start = 1'b0;
        total++;
        if (!done || done_cyc !== 8 || wecnt !== 7 || rf.we !== 1'b0) begin
            bad++;
            $display("FAIL clear_done: done=%b cycle=%0d writes=%0d we=%b required 1 8 7 0",
                     done, done_cyc, wecnt, rf.we);
        end
        for (int i = 1; i < NUM_REGS; i++) model[i] = '0;
        step();
        step();
        total++;
        if (busy !== 1'b0 || rf.we !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL clear_norestart: busy=%b we=%b done=%b required 0 0 0", busy, rf.we, done);
        end
    endtask

    task automatic test_reset();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || rf.we !== 1'b0 || rf.out_valid !== 1'b0 ||
            checksum !== '0 || rf.ra !== '0 || rf.wa !== '0 || rf.wd !== '0 ||
            rf.out_data !== '0 || rf.out_idx !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b we=%b valid=%b cks=%h ra=%0d wa=%0d data=%h idx=%0d required all 0",
                     busy, done, rf.we, rf.out_valid, checksum, rf.ra, rf.wa, rf.out_data, rf.out_idx);
        end
    endtask

    task automatic test_dump_basic();
        for (int i = 0; i < NUM_REGS; i++) model[i] = DATA_W'(8'h11 * i);
        preload();
        run_dump(0, -1, 1);
    endtask

    task automatic test_checksum_wrap();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        model[7] = 8'hFF; model[6] = 8'h02;
        preload();
        run_dump(0, -1, 1);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 3; k++) begin
            random_model();
            preload();
            run_dump(1, -1, 0);
        end
    endtask

    task automatic test_clear();
        random_model();
        preload();
        run_clear();
        run_dump(0, -1, 1);
    endtask

    task automatic test_abort();
        random_model();
        preload();
        run_dump(0, 3, 0);
        run_dump(1, -1, 0);
    endtask

    task automatic test_abort_start_idle();
        start = 1'b1; mode = CMD_DUMP; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0 || rf.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_start_idle: busy=%b valid=%b required 0 0", busy, rf.out_valid);
        end
    endtask

    task automatic test_rst_mid_clear();
        random_model();
        preload();
        start = 1'b1; mode = CMD_CLEAR;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (rf.we !== 1'b0 || busy !== 1'b0 || rf.out_valid !== 1'b0 || checksum !== '0) begin
            bad++;
            $display("FAIL rst_mid_clear: we=%b busy=%b valid=%b cks=%h required 0 0 0 00",
                     rf.we, busy, rf.out_valid, checksum);
        end
        model[1] = '0; model[2] = '0;
        @(negedge clk);
        rst = 1'b0;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_release_idle: busy=%b required 0", busy);
        end
        run_dump(0, -1, 1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            random_model();
            preload();
            if ($urandom_range(0, 1) == 1) run_clear();
            run_dump(int'($urandom_range(0, 1)), -1, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
        pl_we = 1'b0; pl_wa = '0; pl_wd = '0;
        rf.out_ready = 1'b0;
        #3;
        test_reset();
        step();
        step();
        rst = 1'b0;
        step();
        test_dump_basic();
        test_checksum_wrap();
        test_backpressure();
        test_clear();
        test_abort();
        test_abort_start_idle();
        test_rst_mid_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
